// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_stage_pkg
// Purpose : Shared pipeline definitions for the five-stage LoongArch core.
//           Holds the reset fetch address, the bus widths, and the field
//           offsets of the branch bus (ID->IF) and the IF->ID bus.
//           Also provides pack/unpack helpers for both buses.
// Revision: 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    // Address of the first fetch after reset.
    localparam logic [31:0] RESET_PC     = 32'h1C00_0000;

    // Bus widths.
    localparam int          IF_ID_BUS_WD = 64;
    localparam int          BR_BUS_WD    = 33;

    // Branch bus field offsets: {taken, target}.
    localparam int          BR_TAKEN_BIT  = 32;
    localparam int          BR_TARGET_MSB = 31;
    localparam int          BR_TARGET_LSB = 0;

    // IF->ID bus field offsets: {inst, pc}.
    localparam int          ID_INST_MSB   = 63;
    localparam int          ID_INST_LSB   = 32;
    localparam int          ID_PC_MSB     = 31;
    localparam int          ID_PC_LSB     = 0;

    // Decoded view of the branch bus.
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    // Decoded view of the IF->ID bus.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } if_id_bus_t;

    // Split the raw branch bus into its fields.
    function automatic br_bus_t unpack_br(input logic [BR_BUS_WD-1:0] bus);
        br_bus_t b;
        b.taken  = bus[BR_TAKEN_BIT];
        b.target = bus[BR_TARGET_MSB:BR_TARGET_LSB];
        return b;
    endfunction

    // Assemble the IF->ID bus, inst in the upper half.
    function automatic logic [IF_ID_BUS_WD-1:0] pack_if_id(input logic [31:0] inst,
                                                           input logic [31:0] pc);
        logic [IF_ID_BUS_WD-1:0] bus;
        bus                          = '0;
        bus[ID_INST_MSB:ID_INST_LSB] = inst;
        bus[ID_PC_MSB:ID_PC_LSB]     = pc;
        return bus;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_stage
// Purpose : Instruction-fetch stage. Holds the fetch PC and drives a
//           synchronous instruction SRAM. Hands {inst, pc} to decode under a
//           valid/allowin handshake. Redirects on a taken branch from decode
//           and squashes the wrong-path instruction on that cycle.
//
// Ports   :
//   clk              in   1   rising-edge clock
//   reset            in   1   asynchronous, active-low reset
//   ID_allowin       in   1   decode can accept an instruction this cycle
//   br_signal        in  33   {br_taken, br_target[31:0]} from decode
//   inst_sram_en     out  1   SRAM read enable
//   inst_sram_we     out  4   SRAM byte write enables (always 0)
//   inst_sram_addr   out 32   SRAM fetch address (= next PC)
//   inst_sram_wdata  out 32   SRAM write data (always 0)
//   inst_sram_rdata  in  32   SRAM read data, valid the cycle after a request
//   ID_signal_valid  out  1   ID_signal carries a live instruction
//   ID_signal        out 64   {inst[31:0], pc[31:0]}
//
// Revision: 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ID_allowin,
    input  logic [BR_BUS_WD-1:0]    br_signal,
    output logic                    inst_sram_en,
    output logic [3:0]              inst_sram_we,
    output logic [31:0]             inst_sram_addr,
    output logic [31:0]             inst_sram_wdata,
    input  logic [31:0]             inst_sram_rdata,
    output logic                    ID_signal_valid,
    output logic [IF_ID_BUS_WD-1:0] ID_signal
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] inst_buf;
    logic        buf_valid;

    // ------------------------------------------------------------------
    // Handshake and next-PC
    // ------------------------------------------------------------------
    br_bus_t     br;
    logic        fs_allowin;
    logic        br_fire;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic [31:0] inst;

    assign br         = unpack_br(br_signal);

    // IF has no internal work to finish, so it can always go once valid;
    // it accepts a new fetch whenever it is empty or decode takes its data.
    assign fs_allowin = !fs_valid || ID_allowin;

    // A branch only takes effect on the cycle the branch itself leaves
    // decode; while decode is stalled the request is ignored.
    assign br_fire    = br.taken && ID_allowin;

    // Modulo-2^32 sequential address; wraps from FFFF_FFFC to 0.
    assign seq_pc     = fs_pc + 32'd4;
    assign nextpc     = br_fire ? br.target : seq_pc;

    // ------------------------------------------------------------------
    // SRAM request. Reset is active-low: no request while it is asserted.
    // ------------------------------------------------------------------
    assign inst_sram_en    = reset && fs_allowin;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;

    // ------------------------------------------------------------------
    // Fetch PC, valid and stall buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fs_valid  <= 1'b0;
            // One word below RESET_PC so the first fs_pc+4 hits RESET_PC.
            fs_pc     <= RESET_PC - 32'd4;
            inst_buf  <= 32'h0000_0000;
            buf_valid <= 1'b0;
        end else if (fs_allowin) begin
            fs_valid  <= 1'b1;
            fs_pc     <= nextpc;
            buf_valid <= 1'b0;
        end else if (!buf_valid) begin
            // First stalled cycle: the SRAM is not re-enabled, so its output
            // cannot be relied on afterwards. Capture the word now.
            inst_buf  <= inst_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output to decode
    // ------------------------------------------------------------------
    assign inst            = buf_valid ? inst_buf : inst_sram_rdata;

    // The sequential instruction currently in IF is wrong-path when a
    // branch fires; drop it while the target is being requested.
    assign ID_signal_valid = fs_valid && !br_fire;
    assign ID_signal       = pack_if_id(inst, fs_pc);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_stage
// Purpose : Directed self-checking bench for if_stage. A small synchronous
//           SRAM model returns ~addr for every fetched word. The data can be
//           overridden to 0xDEADBEEF to show that stalled output does not
//           depend on rdata.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        ID_allowin;
    logic [32:0] br_signal;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        ID_signal_valid;
    logic [63:0] ID_signal;

    logic [31:0] rdata_q;
    logic        corrupt;

    int n_checks = 0;
    int n_fails  = 0;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ID_allowin      (ID_allowin),
        .br_signal       (br_signal),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .ID_signal_valid (ID_signal_valid),
        .ID_signal       (ID_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: contents at address a are ~a.
    always @(posedge clk) begin
        if (inst_sram_en) rdata_q <= ~inst_sram_addr;
    end
    assign inst_sram_rdata = corrupt ? 32'hDEAD_BEEF : rdata_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the full IF->ID view: valid, inst, pc.
    task automatic check_id(input string tag, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc);
        check({tag, ".valid"}, {63'd0, ID_signal_valid}, {63'd0, v});
        if (v) check({tag, ".bus"}, ID_signal, {inst, pc});
    endtask

    task automatic check_req(input string tag, input logic en, input logic [31:0] addr);
        check({tag, ".en"}, {63'd0, inst_sram_en}, {63'd0, en});
        if (en) check({tag, ".addr"}, {32'd0, inst_sram_addr}, {32'd0, addr});
    endtask

    // Advance to the next negedge, then let combinational outputs settle.
    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        ID_allowin = 1'b1;
        br_signal  = 33'd0;
        corrupt    = 1'b0;
        rdata_q    = 32'd0;

        // ---------------- reset held for 5 cycles ----------------
        repeat (5) step();
        #1;
        check("rst.valid", {63'd0, ID_signal_valid}, 64'd0);
        check("rst.en",    {63'd0, inst_sram_en},    64'd0);
        check("rst.pc",    {32'd0, ID_signal[31:0]}, {32'd0, 32'h1BFF_FFFC});
        check("rst.we",    {60'd0, inst_sram_we},    64'd0);
        check("rst.wdata", {32'd0, inst_sram_wdata}, 64'd0);

        // ---------------- release: first request ----------------
        step(); reset = 1'b1; #1;
        check_req("rel", 1'b1, 32'h1C00_0000);
        check("rel.valid", {63'd0, ID_signal_valid}, 64'd0);

        // ---------------- streaming ----------------
        step(); #1;
        check_id("s0", 1'b1, ~32'h1C00_0000, 32'h1C00_0000);
        check_req("s0", 1'b1, 32'h1C00_0004);
        step(); #1;
        check_id("s1", 1'b1, ~32'h1C00_0004, 32'h1C00_0004);

        // ---------------- stall at 0x1C000008 for 3 cycles ----------------
        step(); ID_allowin = 1'b0; #1;
        check_id("st0", 1'b1, ~32'h1C00_0008, 32'h1C00_0008);
        check_req("st0", 1'b0, 32'h0);
        step(); corrupt = 1'b1; #1;
        check_id("st1", 1'b1, ~32'h1C00_0008, 32'h1C00_0008);
        check_req("st1", 1'b0, 32'h0);
        step(); #1;
        check_id("st2", 1'b1, ~32'h1C00_0008, 32'h1C00_0008);
        check_req("st2", 1'b0, 32'h0);
        // release; rdata still corrupted, buffer must supply the word
        step(); ID_allowin = 1'b1; #1;
        check_id("strel", 1'b1, ~32'h1C00_0008, 32'h1C00_0008);
        check_req("strel", 1'b1, 32'h1C00_000C);
        step(); corrupt = 1'b0; #1;
        check_id("s3", 1'b1, ~32'h1C00_000C, 32'h1C00_000C);

        // ---------------- taken branch while IF holds 0x1C000010 ----------------
        step(); br_signal = {1'b1, 32'h1C00_0100}; #1;
        check("br.valid", {63'd0, ID_signal_valid}, 64'd0);
        check_req("br", 1'b1, 32'h1C00_0100);
        step(); br_signal = 33'd0; #1;
        check_id("brt", 1'b1, ~32'h1C00_0100, 32'h1C00_0100);
        check_req("brt", 1'b1, 32'h1C00_0104);

        // ---------------- branch during decode stall ----------------
        ID_allowin = 1'b0; br_signal = {1'b1, 32'h1C00_0200}; #1;
        check_id("bs0", 1'b1, ~32'h1C00_0100, 32'h1C00_0100);
        check_req("bs0", 1'b0, 32'h0);
        step(); #1;
        check_id("bs1", 1'b1, ~32'h1C00_0100, 32'h1C00_0100);
        check_req("bs1", 1'b0, 32'h0);
        step(); ID_allowin = 1'b1; #1;
        check("bs2.valid", {63'd0, ID_signal_valid}, 64'd0);
        check_req("bs2", 1'b1, 32'h1C00_0200);
        step(); br_signal = 33'd0; #1;
        check_id("bst", 1'b1, ~32'h1C00_0200, 32'h1C00_0200);

        // ---------------- PC wrap via branch to FFFF_FFFC ----------------
        br_signal = {1'b1, 32'hFFFF_FFFC}; #1;
        check_req("wbr", 1'b1, 32'hFFFF_FFFC);
        step(); br_signal = 33'd0; #1;
        check_id("w0", 1'b1, ~32'hFFFF_FFFC, 32'hFFFF_FFFC);
        check_req("w0", 1'b1, 32'h0000_0000);
        step(); #1;
        check_id("w1", 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);

        // ---------------- async reset between edges ----------------
        #1; reset = 1'b0; #1;
        check("ar.valid", {63'd0, ID_signal_valid}, 64'd0);
        check("ar.en",    {63'd0, inst_sram_en},    64'd0);
        check("ar.pc",    {32'd0, ID_signal[31:0]}, {32'd0, 32'h1BFF_FFFC});
        repeat (2) step();
        #1;
        check("ar2.en", {63'd0, inst_sram_en}, 64'd0);
        step(); reset = 1'b1; #1;
        check_req("rr", 1'b1, 32'h1C00_0000);
        step(); #1;
        check_id("rr0", 1'b1, ~32'h1C00_0000, 32'h1C00_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage LoongArch pipeline, producer end of the IF→ID interface. Holds the fetch PC and drives the synchronous instruction SRAM. Delivers `{inst, pc}` to the decode stage under a valid/allowin handshake. Consumes the decode stage's branch bus: it redirects fetch and squashes the wrong-path instruction.

## Interface
- `RESET_PC`, 32'h1C00_0000: address of the first fetch after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `ID_allowin` in 1: decode stage can accept an instruction this cycle.
- `br_signal` in 33: `[32]` br_taken, `[31:0]` br_target, combinational from decode.
- `inst_sram_en` out 1: read enable.
- `inst_sram_we` out 4: tied to 4'b0.
- `inst_sram_addr` out 32: fetch address.
- `inst_sram_wdata` out 32: tied to 0.
- `inst_sram_rdata` in 32: read data, valid the cycle after an enabled request.
- `ID_signal_valid` out 1: `ID_signal` holds a live instruction.
- `ID_signal` out 64: `{inst[31:0], pc[31:0]}`, with inst in the upper 32 bits.

## Operation
- **State:** `fs_valid`, `fs_pc[31:0]`, `inst_buf[31:0]`, `buf_valid`.
- **Reset values:** `fs_valid=0`, `buf_valid=0`, `fs_pc=RESET_PC-4`, `inst_buf=0`.
- **Reset outputs:** while `reset` is low, `inst_sram_en=0` and `ID_signal_valid=0`.
- **Handshake signals:**
  - `fs_allowin = !fs_valid | ID_allowin`. IF is always ready-to-go when valid.
  - `br_fire = br_signal[32] & ID_allowin`. A branch counts only on the cycle the branch leaves decode. A taken branch seen while decode is stalled is ignored until decode advances.
- **Next PC:** `nextpc = br_fire ? br_signal[31:0] : fs_pc + 4`. Addition is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- **SRAM request:**
  - `inst_sram_en = reset & fs_allowin`.
  - `inst_sram_addr = nextpc`.
- **Update when `fs_allowin`:** `fs_valid<=1`, `fs_pc<=nextpc`, `buf_valid<=0`.
- **Stall hold** (`fs_valid & !ID_allowin`):
  - On the first stall cycle (`!buf_valid`): `inst_buf<=inst_sram_rdata`, `buf_valid<=1`.
  - Later stall cycles hold both registers.
  - SRAM rdata is not trusted to persist while `en=0`.
- **Instruction select:** `inst = buf_valid ? inst_buf : inst_sram_rdata`.
- **Squash:** `ID_signal_valid = fs_valid & !br_fire`.
  - The sequential instruction in IF is discarded on the branch cycle.
  - The target is requested on that same cycle.
- **Branch to self-address:** no special case.

## Timing
- **Reset release:** the first cycle after the `reset` rise issues `en=1`, `addr=RESET_PC`.
- **Fetch latency:** the next cycle has `fs_valid=1`, `fs_pc=RESET_PC`, with inst taken from rdata.
- **Throughput:** one instruction per cycle when decode never stalls.
- **Branch penalty:** one bubble.
  - Cycle N: `br_fire`, `ID_signal_valid=0`, `addr=target`.
  - Cycle N+1: the target instruction is presented.
- **Stall entry:** the cycle after stall entry presents `inst_buf`. `ID_signal` stays stable for the whole stall.
- **Reset asserted mid-stream:** all valids drop the same instant. No SRAM request is issued while reset is low.

## Structure
- **Shared pipeline package:**
  - `RESET_PC`.
  - `IF_ID_BUS_WD=64` and `BR_BUS_WD=33`.
  - Field offsets of `br_signal` (taken bit 32, target 31:0).
  - Field offsets of `ID_signal` (inst 63:32, pc 31:0).
- **Sub-modules:** none. A single module is natural; the PC/next-PC logic and the stall buffer are too small to split.

## Test plan
- **Reset/first fetch:** hold `reset=0` 5 cycles, then release → `en=1`, `addr=0x1C000000`. Next cycle `ID_signal={rdata,0x1C000000}`, valid=1.
- **Streaming:** `ID_allowin=1`, SRAM returning mem[addr] → pcs 0x1C000000, …04, …08 on consecutive cycles, each with the matching inst.
- **Stall:** drop `ID_allowin` for 3 cycles while pc=0x1C000008 and corrupt rdata to 0xDEADBEEF during the stall. Required response:
  - `en=0` for all 3 cycles.
  - `ID_signal` holds the original inst and pc.
  - After release, pc 0x1C00000C follows.
- **Taken branch:** `br_signal={1,0x1C000100}` with `ID_allowin=1` while IF holds 0x1C000010. Required response:
  - `ID_signal_valid=0` that cycle.
  - `addr=0x1C000100`.
  - Next cycle pc=0x1C000100, valid=1.
- **Branch during decode stall:** `br_taken=1`, `ID_allowin=0` for 2 cycles, then 1. Required response:
  - No redirect and no squash during the stall.
  - Redirect and squash occur only on the allowin cycle.
- **Async reset mid-stream:** pull `reset` low between clock edges → `ID_signal_valid` and `en` drop immediately. After release, fetch restarts at 0x1C000000.
